// File: rtl/hs_burst_tx.sv
// hs_burst_tx: req/ack handshake burst transmitter.
// An en rising edge launches a burst of BURST_LEN words, one word per
// handshake, in either 4-phase (return-to-zero) or 2-phase (toggle) signalling.
// A per-edge wait counter aborts the burst with a sticky error flag when the
// receiver stalls.
module hs_burst_tx #(
    parameter int  DATA_W     = 6,
    parameter int  BURST_LEN  = 8,
    parameter int  TIMEOUT    = 15,
    parameter int  FOUR_PHASE = 1,
    localparam int CW         = $clog2(BURST_LEN + 1)
) (
    input  logic              clk1,
    input  logic              clr,
    input  logic              en,
    input  logic [DATA_W-1:0] data_in,
    input  logic              ack,
    output logic              req,
    output logic [DATA_W-1:0] data_out,
    output logic              data_rd,
    output logic              busy,
    output logic              complete,
    output logic              timeout_err,
    output logic [CW-1:0]     word_cnt
);
    localparam int            WW       = $clog2(TIMEOUT + 1);
    localparam bit            FP       = (FOUR_PHASE != 0);
    localparam logic [CW-1:0] LEN      = CW'(BURST_LEN);
    localparam logic [CW-1:0] LAST_IDX = CW'(BURST_LEN - 1);
    localparam logic [WW-1:0] WAIT_MAX = WW'(TIMEOUT - 1);

    typedef enum logic [2:0] {IDLE, REQ, RET, DONE, ERR} state_t;

    state_t            state, state_n;
    logic              en_q;
    logic              start;
    logic              hit;
    logic              load;
    logic              req_n, busy_n, err_n;
    logic [DATA_W-1:0] data_n;
    logic [CW-1:0]     cnt_n;
    logic [WW-1:0]     wait_cnt, wait_n;

    assign start = en & ~en_q;

    // State and datapath registers; clr aborts any burst silently.
    always_ff @(posedge clk1) begin
        if (clr) begin
            state       <= IDLE;
            en_q        <= 1'b0;
            req         <= 1'b0;
            data_out    <= '0;
            busy        <= 1'b0;
            timeout_err <= 1'b0;
            word_cnt    <= '0;
            wait_cnt    <= '0;
        end else begin
            state       <= state_n;
            en_q        <= en;
            req         <= req_n;
            data_out    <= data_n;
            busy        <= busy_n;
            timeout_err <= err_n;
            word_cnt    <= cnt_n;
            wait_cnt    <= wait_n;
        end
    end

    // Next-state logic: handshake sequencing, word loading and stall timeout.
    always_comb begin
        state_n  = state;
        req_n    = req;
        data_n   = data_out;
        busy_n   = busy;
        err_n    = timeout_err;
        cnt_n    = word_cnt;
        wait_n   = wait_cnt;
        load     = 1'b0;
        // 4-phase waits for ack high; 2-phase waits for ack to match req.
        hit      = FP ? ack : (ack == req);

        case (state)
            IDLE: begin
                if (start) begin
                    load    = 1'b1;
                    busy_n  = 1'b1;
                    cnt_n   = '0;
                    err_n   = 1'b0;
                    wait_n  = '0;
                    req_n   = FP ? 1'b1 : ~req;
                    state_n = REQ;
                end
            end
            REQ: begin
                if (hit) begin
                    wait_n = '0;
                    cnt_n  = word_cnt + 1'b1;
                    if (FP) begin
                        req_n   = 1'b0;
                        state_n = RET;
                    end else if (word_cnt == LAST_IDX) begin
                        state_n = DONE;
                    end else begin
                        load  = 1'b1;
                        req_n = ~req;
                    end
                end else if (wait_cnt == WAIT_MAX) begin
                    // 2-phase keeps req level so the wire parity stays consistent.
                    state_n = ERR;
                    err_n   = 1'b1;
                    busy_n  = 1'b0;
                    if (FP) req_n = 1'b0;
                end else begin
                    wait_n = wait_cnt + 1'b1;
                end
            end
            RET: begin
                if (!ack) begin
                    wait_n = '0;
                    if (word_cnt == LEN) begin
                        state_n = DONE;
                    end else begin
                        load    = 1'b1;
                        req_n   = 1'b1;
                        state_n = REQ;
                    end
                end else if (wait_cnt == WAIT_MAX) begin
                    state_n = ERR;
                    err_n   = 1'b1;
                    busy_n  = 1'b0;
                end else begin
                    wait_n = wait_cnt + 1'b1;
                end
            end
            DONE: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            ERR: begin
                busy_n  = 1'b0;
                state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase

        if (load) data_n = data_in;
    end

    // data_rd marks the cycle whose closing edge captures data_in.
    always_comb begin
        data_rd  = load & ~clr;
        complete = (state == DONE);
    end

endmodule
